// File: rtl/proc_cache_swap_ctrl_pkg.sv
// Shared types for the ping-pong cache swap controller: FSM state encoding
// and the bank encoding used on sel / fill_bank.
package proc_cache_swap_ctrl_pkg;

  typedef enum logic [1:0] {
    StStart,
    StFilling,
    StReady,
    StSwap
  } swap_state_e;

  // Bank encoding on the mux select: 0 = cache1, 1 = cache2.
  localparam logic BANK_CACHE1 = 1'b0;
  localparam logic BANK_CACHE2 = 1'b1;

endpackage

// File: rtl/proc_cache_swap_ctrl_fill_timeout_cnt.sv
// Fill watchdog: counts cycles while enabled and flags expiry once the count
// reaches TIMEOUT_CYCLES-1. Clear has priority over enable.
module proc_cache_swap_ctrl_fill_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/proc_cache_swap_ctrl.sv
// Ping-pong bank swap controller for the processor/cache mux. The processor
// owns bank sel, the loader refills bank ~sel; a swap is only taken once the
// loader bank is full. Optional macro SWAP_CNT_EN adds a 16-bit swap counter.
module proc_cache_swap_ctrl
  import proc_cache_swap_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        proc_swap_req,
  output logic        proc_swap_ack,
  input  logic        proc_WE_in,
  output logic        proc_WE_out,
  output logic        sel,
  output logic        fill_start,
  output logic        fill_bank,
  input  logic        fill_done,
  output logic        fill_err,
  input  logic        err_clr
`ifdef SWAP_CNT_EN
  ,
  output logic [15:0] swap_cnt
`endif
);

  swap_state_e state_q;
  logic        sel_q;
  logic        ack_q;
  logic        start_q;
  logic        err_q;
  logic        tmo_expired;

  proc_cache_swap_ctrl_fill_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fill_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == StStart),
    .en_i      (state_q == StFilling),
    .expired_o (tmo_expired)
  );

  // Swap FSM with registered outputs. START leaves only once the fill_start
  // pulse is on the wire; out of reset that costs one extra START cycle, while
  // entries from SWAP or a timeout raise the pulse on the entering edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStart;
      sel_q   <= BANK_CACHE1;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      // A timeout below overrides this clear.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        StStart: begin
          if (start_q) begin
            state_q <= StFilling;
          end else begin
            start_q <= 1'b1;
          end
        end
        StFilling: begin
          if (fill_done) begin
            state_q <= StReady;
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            start_q <= 1'b1;
            state_q <= StStart;
          end
        end
        StReady: begin
          if (proc_swap_req) begin
            state_q <= StSwap;
          end
        end
        StSwap: begin
          sel_q   <= ~sel_q;
          ack_q   <= 1'b1;
          start_q <= 1'b1;
          state_q <= StStart;
        end
        default: state_q <= StStart;
      endcase
    end
  end

`ifdef SWAP_CNT_EN
  logic [15:0] swap_cnt_q;

  // Counts completed swaps; advances on the same edge that raises the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_q <= '0;
    end else if (state_q == StSwap) begin
      swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  assign swap_cnt = swap_cnt_q;
`endif

  assign proc_swap_ack = ack_q;
  assign sel           = sel_q;
  assign fill_start    = start_q;
  assign fill_err      = err_q;
  assign fill_bank     = (sel_q == BANK_CACHE1) ? BANK_CACHE2 : BANK_CACHE1;
  // Writes are blocked for the single cycle in which the banks change hands.
  assign proc_WE_out   = proc_WE_in & (state_q != StSwap);

endmodule

// File: tb/tb_proc_cache_swap_ctrl.sv
// Bench for proc_cache_swap_ctrl: directed swap table on a default instance,
// timeout/reset sequences, and random traffic on a short-timeout instance
// checked against a behavioural model.
module tb_proc_cache_swap_ctrl;

  localparam int T_SHORT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic req, we, done, clr;
  logic ack, we_out, sel, fstart, fbank, ferr;
  logic t_req, t_we, t_done, t_clr;
  logic t_ack, t_we_out, t_sel, t_fstart, t_fbank, t_ferr;
`ifdef SWAP_CNT_EN
  logic [15:0] cnt, t_cnt;
`endif

  proc_cache_swap_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .proc_swap_req (req),
    .proc_swap_ack (ack),
    .proc_WE_in    (we),
    .proc_WE_out   (we_out),
    .sel           (sel),
    .fill_start    (fstart),
    .fill_bank     (fbank),
    .fill_done     (done),
    .fill_err      (ferr),
    .err_clr       (clr)
`ifdef SWAP_CNT_EN
    ,
    .swap_cnt      (cnt)
`endif
  );

  proc_cache_swap_ctrl #(
    .TIMEOUT_CYCLES (T_SHORT)
  ) u_dut_to (
    .clk           (clk),
    .rst_n         (rst_n),
    .proc_swap_req (t_req),
    .proc_swap_ack (t_ack),
    .proc_WE_in    (t_we),
    .proc_WE_out   (t_we_out),
    .sel           (t_sel),
    .fill_start    (t_fstart),
    .fill_bank     (t_fbank),
    .fill_done     (t_done),
    .fill_err      (t_ferr),
    .err_clr       (t_clr)
`ifdef SWAP_CNT_EN
    ,
    .swap_cnt      (t_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

`ifdef SWAP_CNT_EN
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
`endif

  // Directed swap table: fill_done cycle, request-rise cycle, spurious
  // fill_done cycle (0 = none), expected ack cycle; cycle 0 = fill_start.
  typedef struct {
    int d;
    int r;
    int d2;
    int ack_at;
  } vec_t;
  vec_t tbl[5];

  // Behavioural model of the short-timeout instance.
  bit          m_sel, m_ack, m_start, m_err;
  bit          m_pre, m_filling, m_full, m_switching;
  int          m_age;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_sel = 0; m_ack = 0; m_start = 0; m_err = 0;
    m_pre = 1; m_filling = 0; m_full = 0; m_switching = 0;
    m_age = 0; m_cnt = 16'd0;
  endtask

  task automatic model_step();
    bit n_sel   = m_sel;
    bit n_ack   = m_switching;
    bit n_start = 0;
    bit n_fill  = 0;
    bit n_full  = 0;
    bit n_sw    = 0;
    bit tmo     = 0;
    int n_age   = 0;
    if (m_pre) begin
      n_start = 1;
    end else if (m_start) begin
      n_fill = 1;
      n_age  = 1;
    end else if (m_filling) begin
      if (t_done) n_full = 1;
      else if (m_age == T_SHORT) begin
        tmo     = 1;
        n_start = 1;
      end else begin
        n_fill = 1;
        n_age  = m_age + 1;
      end
    end else if (m_full) begin
      if (t_req) n_sw = 1;
      else n_full = 1;
    end else if (m_switching) begin
      n_sel   = !m_sel;
      n_start = 1;
    end
    if (tmo) m_err = 1;
    else if (t_clr) m_err = 0;
    if (m_switching) m_cnt = m_cnt + 16'd1;
    m_pre = 0;
    m_sel = n_sel; m_ack = n_ack; m_start = n_start;
    m_filling = n_fill; m_full = n_full; m_switching = n_sw; m_age = n_age;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_sel;
    tbl[0] = '{10, 11, 12, 13};
    tbl[1] = '{50, 3, 0, 53};
    tbl[2] = '{1, 1, 0, 4};
    tbl[3] = '{5, 20, 12, 22};
    tbl[4] = '{7, 8, 0, 10};

    rst_n = 1'b0;
    req = 0; we = 1; done = 0; clr = 0;
    t_req = 0; t_we = 1; t_done = 0; t_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", sel, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_fill_start", fstart, 1'b0);
    check("rst_fill_err", ferr, 1'b0);
    check("rst_fill_bank", fbank, 1'b1);
    check("rst_we_out_hi", we_out, 1'b1);
    we = 0;
    #1 check("rst_we_out_lo", we_out, 1'b0);
    we = 1;

    // Release: fill_start one cycle later, towards cache2.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel0_fill_start", fstart, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel1_fill_start", fstart, 1'b1);
    check("rel1_fill_bank", fbank, 1'b1);
    check("rel1_sel", sel, 1'b0);
    check("rel1_ack", ack, 1'b0);

    exp_sel = 1'b0;
    foreach (tbl[i]) begin
      for (int c = 1; c <= tbl[i].ack_at; c++) begin
        @(posedge clk); #1;
        done = (c == tbl[i].d) || (c == tbl[i].d2);
        req  = (c >= tbl[i].r) && (c < tbl[i].ack_at);
        @(negedge clk);
        if (c == tbl[i].ack_at) exp_sel = ~exp_sel;
        check("tbl_ack", ack, c == tbl[i].ack_at);
        check("tbl_fill_start", fstart, c == tbl[i].ack_at);
        check("tbl_we_out", we_out, c != tbl[i].ack_at - 1);
        check("tbl_sel", sel, exp_sel);
        check("tbl_fill_bank", fbank, ~exp_sel);
        check("tbl_fill_err", ferr, 1'b0);
      end
    end
    done = 0;

    // Reset asserted while in SWAP with sel=1: outputs drop at once.
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      done = (c == 3);
      req  = 1'b1;
      @(negedge clk);
    end
    check("swap_we_out", we_out, 1'b0);
    check("swap_sel_before", sel, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstswap_sel", sel, 1'b0);
    check("rstswap_ack", ack, 1'b0);
    check("rstswap_fill_start", fstart, 1'b0);
    check("rstswap_we_out", we_out, 1'b1);
    req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstswap_ack_held", ack, 1'b0);

    // Release again; watch two timeouts on the short instance, the second one
    // coinciding with err_clr.
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      t_clr = (c == 14) || (c == 18);
      @(negedge clk);
      check("to_fill_start", t_fstart, (c == 1) || (c == 10) || (c == 19));
      check("to_fill_err", t_ferr, ((c >= 10) && (c <= 14)) || (c == 19));
      if (c == 1) check("main_rel_fill_start", fstart, 1'b1);
    end
    t_clr = 0;

    // Random traffic on the short-timeout instance.
    @(negedge clk) rst_n = 1'b0;
    t_req = 0; t_done = 0;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      t_done = ($urandom_range(5) == 0);
      t_clr  = ($urandom_range(9) == 0);
      t_we   = 1'($urandom_range(1));
      if (t_req) begin
        if (m_ack && ($urandom_range(7) != 0)) t_req = 0;
      end else if ($urandom_range(3) == 0) begin
        t_req = 1;
      end
      @(negedge clk);
      check("rnd_sel", t_sel, m_sel);
      check("rnd_ack", t_ack, m_ack);
      check("rnd_fill_start", t_fstart, m_start);
      check("rnd_fill_bank", t_fbank, !m_sel);
      check("rnd_fill_err", t_ferr, m_err);
      check("rnd_we_out", t_we_out, t_we & !m_switching);
`ifdef SWAP_CNT_EN
      check16("rnd_swap_cnt", t_cnt, m_cnt);
`endif
      model_step();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
